// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus (imem port, hazard/redirect controls, IF/ID outputs); FETCH_PERF_CNT_EN adds perf counters
interface fetch_stage_if;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] instr;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus1;
   logic        if_id_valid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_bubble_cnt;
   modport master (
      input  stall, redirect, redirect_pc, instr,
      output im_addr, im_rd_en, if_id_instr, if_id_pc_plus1, if_id_valid, halted,
             perf_fetch_cnt, perf_bubble_cnt
   );
   modport slave (
      output stall, redirect, redirect_pc, instr,
      input  im_addr, im_rd_en, if_id_instr, if_id_pc_plus1, if_id_valid, halted,
             perf_fetch_cnt, perf_bubble_cnt
   );
`else
   modport master (
      input  stall, redirect, redirect_pc, instr,
      output im_addr, im_rd_en, if_id_instr, if_id_pc_plus1, if_id_valid, halted
   );
   modport slave (
      output stall, redirect, redirect_pc, instr,
      input  im_addr, im_rd_en, if_id_instr, if_id_pc_plus1, if_id_valid, halted
   );
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem fetch, IF/ID register, stall/redirect/HLT; FETCH_PERF_CNT_EN adds fetch/bubble counters
module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_INSTR  = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
   input logic clk,
   input logic rst,
   fetch_stage_if.master bus
);
   typedef enum logic {RUN, HALT} state_t;
   state_t      state;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus1;
   logic        ifid_valid;
   logic        halted;
   logic        is_hlt;
   assign pc_plus1 = pc + 16'd1;
   assign is_hlt   = bus.instr[15:12] == HLT_OPCODE;
   assign bus.im_addr        = pc;
   assign bus.im_rd_en       = ~rst & (state == RUN);
   assign bus.if_id_instr    = ifid_instr;
   assign bus.if_id_pc_plus1 = ifid_pc_plus1;
   assign bus.if_id_valid    = ifid_valid;
   assign bus.halted         = halted;
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         state         <= RUN;
         ifid_instr    <= NOP_INSTR;
         ifid_pc_plus1 <= 16'h0000;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
      end else if (bus.redirect) begin
         pc            <= bus.redirect_pc;
         state         <= RUN;
         ifid_instr    <= NOP_INSTR;
         ifid_pc_plus1 <= 16'h0000;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
      end else if (!bus.stall) begin
         if (state == RUN) begin
            ifid_instr    <= bus.instr;
            ifid_pc_plus1 <= pc_plus1;
            ifid_valid    <= 1'b1;
            // HLT leaves pc parked on its own address
            pc            <= is_hlt ? pc : pc_plus1;
            state         <= is_hlt ? HALT : RUN;
            halted        <= is_hlt;
         end else begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
         end
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt;
   logic [15:0] bubble_cnt;
   logic        load_valid;
   logic        load_bubble;
   assign load_valid  = ~bus.redirect & ~bus.stall & (state == RUN);
   assign load_bubble = bus.redirect | (~bus.stall & (state == HALT));
   assign bus.perf_fetch_cnt  = fetch_cnt;
   assign bus.perf_bubble_cnt = bubble_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= 16'h0000;
         bubble_cnt <= 16'h0000;
      end else begin
         if (load_valid && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
         if (load_bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage, plus a RESET_PC=FFFF wrap instance
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] mem [0:255];
   always #5 clk = ~clk;
   fetch_stage_if bus ();
   fetch_stage_if bus2 ();
   fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
   fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (.clk(clk), .rst(rst), .bus(bus2));
   assign bus.instr  = mem[bus.im_addr[7:0]];
   assign bus2.instr = mem[bus2.im_addr[7:0]];
   assign bus2.stall       = 1'b0;
   assign bus2.redirect    = 1'b0;
   assign bus2.redirect_pc = 16'h0000;
   typedef struct {
      logic [15:0] instr;
      logic [15:0] pcp1;
      logic        valid;
      logic [15:0] addr;
      logic        rd_en;
      logic        halted;
      int          kind;
   } exp_t;
   exp_t exp_q[$];
   int fetch_e = 0;
   int bubble_e = 0;
   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic step(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                       input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                       input logic [15:0] ea, input logic er, input logic eh, input int kind);
      exp_t e;
      rst = r;
      bus.stall = st;
      bus.redirect = rd;
      bus.redirect_pc = rpc;
      e.instr = ei; e.pcp1 = ep; e.valid = ev; e.addr = ea;
      e.rd_en = er; e.halted = eh; e.kind = kind;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask
   // kind: 0 hold, 1 valid load, 2 bubble load, 3 reset
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         fetch_e  = e.kind == 3 ? 0 : fetch_e + (e.kind == 1 ? 1 : 0);
         bubble_e = e.kind == 3 ? 0 : bubble_e + (e.kind == 2 ? 1 : 0);
         check("if_id_instr", bus.if_id_instr, e.instr);
         check("if_id_pc_plus1", bus.if_id_pc_plus1, e.pcp1);
         check("if_id_valid", {15'd0, bus.if_id_valid}, {15'd0, e.valid});
         check("im_addr", bus.im_addr, e.addr);
         check("im_rd_en", {15'd0, bus.im_rd_en}, {15'd0, e.rd_en});
         check("halted", {15'd0, bus.halted}, {15'd0, e.halted});
`ifdef FETCH_PERF_CNT_EN
         check("perf_fetch_cnt", bus.perf_fetch_cnt, 16'(fetch_e));
         check("perf_bubble_cnt", bus.perf_bubble_cnt, 16'(bubble_e));
`endif
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222; mem[8'h02] = 16'h3333;
      mem[8'h03] = 16'h4444; mem[8'h04] = 16'h5555; mem[8'h05] = 16'hF000;
      mem[8'h10] = 16'h1010; mem[8'h20] = 16'h2020; mem[8'h40] = 16'h4040;
      mem[8'hFF] = 16'hABCD;
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
      @(negedge clk);
      step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 3);
      check("wrap_reset_addr", bus2.im_addr, 16'hFFFF);
      step(0, 0, 0, 16'h0000, 16'h1111, 16'h0001, 1, 16'h0001, 1, 0, 1);
      check("wrap_addr", bus2.im_addr, 16'h0000);
      check("wrap_pc_plus1", bus2.if_id_pc_plus1, 16'h0000);
      check("wrap_instr", bus2.if_id_instr, 16'hABCD);
      step(0, 0, 0, 16'h0000, 16'h2222, 16'h0002, 1, 16'h0002, 1, 0, 1);
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 16'h0000, 16'h2222, 16'h0002, 1, 16'h0002, 1, 0, 0);
      step(0, 0, 0, 16'h0000, 16'h3333, 16'h0003, 1, 16'h0003, 1, 0, 1);
      step(0, 1, 1, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0040, 1, 0, 2);
      step(0, 0, 0, 16'h0000, 16'h4040, 16'h0041, 1, 16'h0041, 1, 0, 1);
      step(0, 0, 1, 16'h0004, 16'h0000, 16'h0000, 0, 16'h0004, 1, 0, 2);
      step(0, 0, 0, 16'h0000, 16'h5555, 16'h0005, 1, 16'h0005, 1, 0, 1);
      step(0, 0, 0, 16'h0000, 16'hF000, 16'h0006, 1, 16'h0005, 0, 1, 1);
      step(0, 0, 0, 16'h0000, 16'h0000, 16'h0006, 0, 16'h0005, 0, 1, 2);
      step(0, 1, 0, 16'h0000, 16'h0000, 16'h0006, 0, 16'h0005, 0, 1, 0);
      step(0, 0, 0, 16'h0000, 16'h0000, 16'h0006, 0, 16'h0005, 0, 1, 2);
      step(0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0010, 1, 0, 2);
      step(0, 0, 0, 16'h0000, 16'h1010, 16'h0011, 1, 16'h0011, 1, 0, 1);
      step(0, 0, 1, 16'h0005, 16'h0000, 16'h0000, 0, 16'h0005, 1, 0, 2);
      step(0, 0, 1, 16'h0020, 16'h0000, 16'h0000, 0, 16'h0020, 1, 0, 2);
      step(0, 0, 0, 16'h0000, 16'h2020, 16'h0021, 1, 16'h0021, 1, 0, 1);
      step(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 3);
      step(0, 0, 0, 16'h0000, 16'h1111, 16'h0001, 1, 16'h0001, 1, 0, 1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core.
- Owns the PC and drives the instruction memory's address and read-enable.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, and HLT detection.
- The instruction memory is word-addressed and latches on clock low, so the word for the current PC is stable before the next rising edge.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- NOP_INSTR, 16'h0000, encoding inserted into IF/ID on flush or bubble.
- HLT_OPCODE, 4'hF, value of instr[15:12] identifying HLT.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit hold request; freezes PC and IF/ID.
- redirect  input  1  taken branch/jump from a later stage.
- redirect_pc  input  16  target PC, valid when redirect=1.
- instr  input  16  word returned by instruction memory for im_addr.
- im_addr  output  16  instruction memory address; equals PC register.
- im_rd_en  output  1  instruction memory read enable.
- if_id_instr  output  16  IF/ID registered instruction.
- if_id_pc_plus1  output  16  IF/ID registered PC+1 (word address of next instr).
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch has stopped on HLT.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = RUN.
  - if_id_instr = NOP_INSTR; if_id_pc_plus1 = 0; if_id_valid = 0; halted = 0.
  - im_rd_en = 0 while rst is high.
- im_addr = pc (combinational from the register).
- im_rd_en = ~rst & (state == RUN).
- States:
  - RUN: normal fetch.
  - HALT: PC frozen; im_rd_en = 0; halted = 1 (registered, set on entry).
- Per-edge priority is rst > redirect > stall > normal.
- Redirect (either state):
  - pc <= redirect_pc.
  - IF/ID <= {NOP_INSTR, 0, valid 0}; the word fetched this cycle is flushed.
  - state <= RUN; halted <= 0.
  - Overrides a simultaneous stall.
- Stall (no redirect): pc, IF/ID and state hold. im_rd_en is unchanged, so memory re-reads the same address.
- Normal in RUN, instr[15:12] != HLT_OPCODE:
  - pc <= pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - IF/ID <= {instr, pc + 1, 1}.
- Normal in RUN, instr[15:12] == HLT_OPCODE:
  - IF/ID <= {instr, pc + 1, 1}; pc holds at the HLT address.
  - state <= HALT; halted <= 1.
- Normal in HALT: IF/ID <= {NOP_INSTR, if_id_pc_plus1 unchanged, 0}. Bubbles drain downstream.
- HLT fetched while a redirect is asserted is flushed; no halt occurs.
- Latency: an instruction at PC p appears on IF/ID one edge after im_addr = p (with no stall).
- Reset asserted mid-stall, mid-halt or mid-redirect returns to the reset values on that edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt [15:0] and perf_bubble_cnt [15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - perf_fetch_cnt increments on each edge where IF/ID loads with valid = 1.
  - perf_bubble_cnt increments on each edge where IF/ID loads with valid = 0. Stall-hold edges do not count.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then release with memory words 0x1111, 0x2222, 0x3333 at addresses 0..2:
  - Edge 1 after release: im_addr 0→1; IF/ID = {0x1111, 1, 1}.
  - Next edge: {0x2222, 2, 1}.
- Stall held high 3 cycles while im_addr = 2:
  - im_addr stays 2; IF/ID stays {0x2222, 2, 1}.
  - On release, IF/ID = {0x3333, 3, 1}.
- redirect = 1, redirect_pc = 0x0040, together with stall = 1:
  - Next edge: im_addr = 0x0040; if_id_valid = 0; if_id_instr = NOP_INSTR.
  - Following edge: IF/ID holds the word at 0x0040 with pc_plus1 0x0041.
- HLT word 0xF000 at address 5:
  - IF/ID = {0xF000, 6, 1}; halted = 1; im_rd_en = 0; im_addr stays 5.
  - Later edges: if_id_valid = 0.
- In HALT, redirect to 0x0010: state RUN; halted = 0; im_addr = 0x0010; im_rd_en = 1.
- Start with RESET_PC = 16'hFFFF: after one fetch, im_addr = 0x0000 and if_id_pc_plus1 = 0x0000.
- With FETCH_PERF_CNT_EN: run the scenarios above and check both counters against the counted valid and bubble loads.
